sample_delay_ctrl: RTL and testbench

- Sequencer for one sample delay FIFO stage in the xpu datapath. It owns the FIFO reset, the delay setting and write gating.
- On enable, or on every software delay change, it flushes the FIFO, holds off writes for a reset-recovery guard window, then counts the prefill to the requested depth.
- Reports locked, busy and a reconfiguration count to the register interface.

---
 rtl/sample_delay_ctrl.sv | 122 ++++++++++++
 tb/tb_sample_delay_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_delay_ctrl.sv
// sample_delay_ctrl: sequencer for one sample delay FIFO stage.
// Flushes the FIFO on enable or on any delay change, waits out the FIFO
// reset-recovery guard window, then prefills to the requested depth
// before reporting locked.
module sample_delay_ctrl #(
    parameter int LOG2_FIFO_DEPTH = 7,
    parameter int RST_CYCLES      = 4,
    parameter int GUARD_CYCLES    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [LOG2_FIFO_DEPTH-1:0] delay_req,
    input  logic                       delay_apply,
    input  logic                       sample_valid_in,
    output logic                       fifo_rst,
    output logic [LOG2_FIFO_DEPTH-1:0] fifo_delay_ctl,
    output logic                       fifo_wr_valid,
    output logic [LOG2_FIFO_DEPTH:0]   fill_count,
    output logic                       locked,
    output logic                       busy,
    output logic [15:0]                reconfig_count
);

    typedef enum logic [2:0] {IDLE, FLUSH, GUARD, FILL, RUN} state_t;

    localparam int MAX_CYC = (RST_CYCLES > GUARD_CYCLES) ? RST_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             flush_start;
    logic             fill_done;

    // Prefill target reached: registered count has caught up with the active delay.
    assign fill_done = ({1'b0, fifo_delay_ctl} == fill_count);

    // Write gating and status flags decode straight from the registered state.
    assign fifo_wr_valid = sample_valid_in & ((state == FILL) | (state == RUN));
    assign locked        = (state == RUN);
    assign busy          = (state == FLUSH) | (state == GUARD) | (state == FILL);

    // Next-state and phase counter; enable drop beats delay_apply, which beats normal sequencing.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        flush_start = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt   = FLUSH;
                    cnt_nxt     = CNT_W'(RST_CYCLES - 1);
                    flush_start = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = GUARD;
                    cnt_nxt   = CNT_W'(GUARD_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GUARD: begin
                if (cnt == '0) state_nxt = FILL;
                else           cnt_nxt   = cnt - 1'b1;
            end
            FILL: begin
                if (fill_done) state_nxt = RUN;
            end
            RUN: ;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            if (!enable) begin
                state_nxt = IDLE;
            end else if (delay_apply) begin
                // Any apply while active resyncs, even with an unchanged value.
                state_nxt   = FLUSH;
                cnt_nxt     = CNT_W'(RST_CYCLES - 1);
                flush_start = 1'b1;
            end
        end
    end

    // State and phase counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // FIFO reset follows the next state so it moves on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) fifo_rst <= 1'b1;
        else     fifo_rst <= (state_nxt == IDLE) | (state_nxt == FLUSH);
    end

    // Active delay captures the request on every apply strobe, in any state.
    always_ff @(posedge clk) begin
        if (rst)              fifo_delay_ctl <= '0;
        else if (delay_apply) fifo_delay_ctl <= delay_req;
    end

    // Prefill counter: cleared at each flush, counts passed samples in FILL only.
    always_ff @(posedge clk) begin
        if (rst)                                  fill_count <= '0;
        else if (flush_start)                     fill_count <= '0;
        else if ((state == FILL) && fifo_wr_valid) fill_count <= fill_count + 1'b1;
    end

    // Saturating count of flushes started.
    always_ff @(posedge clk) begin
        if (rst)                                         reconfig_count <= '0;
        else if (flush_start && (reconfig_count != 16'hFFFF)) reconfig_count <= reconfig_count + 1'b1;
    end

endmodule

// File: tb/tb_sample_delay_ctrl.sv
// tb_sample_delay_ctrl: directed + randomized bench for sample_delay_ctrl.
// The reference tracks time since the last flush start and derives the
// phase from that age, rather than stepping a state machine.
module tb_sample_delay_ctrl;

    localparam int W  = 7;
    localparam int RC = 4;
    localparam int GC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [W-1:0] delay_req;
    logic         delay_apply;
    logic         sample_valid_in;
    logic         fifo_rst;
    logic [W-1:0] fifo_delay_ctl;
    logic         fifo_wr_valid;
    logic [W:0]   fill_count;
    logic         locked;
    logic         busy;
    logic [15:0]  reconfig_count;

    sample_delay_ctrl #(.LOG2_FIFO_DEPTH(W), .RST_CYCLES(RC), .GUARD_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .delay_req(delay_req),
        .delay_apply(delay_apply), .sample_valid_in(sample_valid_in),
        .fifo_rst(fifo_rst), .fifo_delay_ctl(fifo_delay_ctl),
        .fifo_wr_valid(fifo_wr_valid), .fill_count(fill_count),
        .locked(locked), .busy(busy), .reconfig_count(reconfig_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_on;     // delay stage active (not idle)
    int m_age;    // cycles since the current flush began
    int m_fill;
    int m_delay;
    int m_recfg;
    bit m_run;

    int svi_mode = 0;  // 0 hold, 1 every 3rd cycle, 2 random
    int cyc = 0;
    int r0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit fl, gd, fi;
        fl = m_on && (m_age < RC);
        gd = m_on && (m_age >= RC) && (m_age < RC + GC);
        fi = m_on && !m_run && (m_age >= RC + GC);
        chk("fifo_rst",       fifo_rst,       32'(!m_on || fl));
        chk("fifo_delay_ctl", fifo_delay_ctl, 32'(m_delay));
        chk("fifo_wr_valid",  fifo_wr_valid,  32'(sample_valid_in && (fi || m_run)));
        chk("fill_count",     fill_count,     32'(m_fill));
        chk("locked",         locked,         32'(m_run));
        chk("busy",           busy,           32'(fl || gd || fi));
        chk("reconfig_count", reconfig_count, 32'(m_recfg));
    endtask

    task automatic model_edge();
        bit fill_ph, cnt, done, start;
        if (rst) begin
            m_on = 0; m_age = 0; m_fill = 0; m_delay = 0; m_recfg = 0; m_run = 0;
            return;
        end
        fill_ph = m_on && !m_run && (m_age >= RC + GC);
        cnt     = sample_valid_in && fill_ph;
        done    = fill_ph && (m_fill == m_delay);
        start   = 0;
        if (!m_on)             start = enable;
        else if (!enable)      begin m_on = 0; m_run = 0; end
        else if (delay_apply)  start = 1;
        else begin
            if (m_age < 1000) m_age++;
            if (done) m_run = 1;
        end
        if (start)    m_fill = 0;
        else if (cnt) m_fill++;
        if (delay_apply) m_delay = int'(delay_req);
        if (start) begin
            m_on = 1; m_age = 0; m_run = 0;
            if (m_recfg < 65535) m_recfg++;
        end
    endtask

    task automatic tick();
        if (svi_mode == 1)      sample_valid_in = (cyc % 3 == 0);
        else if (svi_mode == 2) sample_valid_in = 1'($urandom_range(0, 1));
        cyc++;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_lock(input int limit);
        for (int i = 0; i < limit && !locked; i++) tick();
        chk("lock_timeout", locked, 1);
    endtask

    initial begin
        rst = 1; enable = 0; delay_req = '0; delay_apply = 0; sample_valid_in = 0;
        @(posedge clk); model_edge(); #1;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        chk("rst_fifo_rst", fifo_rst, 1);
        chk("rst_delay", fifo_delay_ctl, 0);
        chk("rst_fill", fill_count, 0);
        chk("rst_recfg", reconfig_count, 0);
        chk("rst_wr_valid", fifo_wr_valid, 0);
        @(posedge clk); model_edge(); #1;
        tick();

        // First lock at delay 5, constant samples
        sample_valid_in = 1; delay_req = 7'd5; delay_apply = 1; enable = 1;
        tick();
        delay_apply = 0;
        wait_lock(100);
        chk("lock1_recfg", reconfig_count, 1);
        tick(); tick();

        // Reconfigure to 20 while running
        delay_req = 7'd20; delay_apply = 1;
        tick();
        delay_apply = 0;
        chk("apply20_busy", busy, 1);
        chk("apply20_fifo_rst", fifo_rst, 1);
        chk("apply20_fill", fill_count, 0);
        wait_lock(100);
        chk("lock2_recfg", reconfig_count, 2);
        chk("lock2_delay", fifo_delay_ctl, 20);

        // Sparse strobes, delay 4
        svi_mode = 1;
        delay_req = 7'd4; delay_apply = 1;
        tick();
        delay_apply = 0;
        wait_lock(100);
        tick(); tick();

        // Double apply during GUARD
        svi_mode = 0; sample_valid_in = 1;
        enable = 0; tick();
        enable = 1; tick();
        for (int i = 0; i < RC + 1; i++) tick();
        chk("in_guard_busy", busy, 1);
        chk("in_guard_rst", fifo_rst, 0);
        r0 = m_recfg;
        delay_req = 7'd10; delay_apply = 1; tick();
        delay_apply = 0; tick();
        delay_req = 7'd12; delay_apply = 1; tick();
        delay_apply = 0;
        for (int i = 0; i < RC + GC - 1; i++) tick();
        chk("guard_window_no_wr", fifo_wr_valid, 0);
        wait_lock(100);
        chk("dbl_delay", fifo_delay_ctl, 12);
        chk("dbl_recfg", reconfig_count, 32'(r0 + 2));

        // Delay 0 with random strobes
        svi_mode = 2;
        delay_req = 7'd0; delay_apply = 1; tick();
        delay_apply = 0;
        wait_lock(40);
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            enable      = ($urandom_range(0, 39) != 0);
            delay_apply = ($urandom_range(0, 24) == 0);
            delay_req   = W'($urandom_range(0, 12));
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0; enable = 1; delay_apply = 0;
        tick();

        // Enable drop mid-FILL
        svi_mode = 0; sample_valid_in = 1;
        delay_req = 7'd30; delay_apply = 1; tick();
        delay_apply = 0;
        for (int i = 0; i < 100 && !(fill_count > 3); i++) tick();
        chk("mid_fill_busy", busy, 1);
        enable = 0; tick();
        chk("drop_fifo_rst", fifo_rst, 1);
        chk("drop_locked", locked, 0);
        chk("drop_busy", busy, 0);

        // rst mid-FLUSH
        enable = 1; tick(); tick();
        rst = 1; tick();
        rst = 0;
        chk("rst2_recfg", reconfig_count, 0);
        chk("rst2_fifo_rst", fifo_rst, 1);
        chk("rst2_delay", fifo_delay_ctl, 0);
        chk("rst2_fill", fill_count, 0);
        chk("rst2_busy", busy, 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
